// File: rtl/mpram_nr1w_pkg.sv
// Shared types for the multi-read, single-write distributed RAM.
package mpram_nr1w_pkg;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } mpram_state_e;

endpackage

// File: rtl/mpram_nr1w_lutram_1r1w.sv
// One async-read, sync-write storage copy; maps to distributed RAM on FPGA builds.
module lutram_1r1w #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

`ifdef _FPGA
  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
`else
  logic [WIDTH-1:0] mem [DEPTH];
`endif

  // No reset: contents are established by the owner's clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mpram_nr1w.sv
// NR-read / 1-write RAM built from replicated 1R1W copies, with post-reset clear sweep,
// optional write-to-read bypass and optional registered read data.
module mpram_nr1w
  import mpram_nr1w_pkg::*;
#(
  parameter int unsigned      DEPTH    = 32,
  parameter int unsigned      WIDTH    = 2,
  parameter int unsigned      NR       = 3,
  parameter bit               BYPASS   = 1'b1,
  parameter bit               OUT_REG  = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int unsigned     AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready_o,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic [NR*AW-1:0]    raddr_i,
  output logic [NR*WIDTH-1:0] rdata_o
);

  mpram_state_e     state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             clr_we;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // Next-state: sweep one entry per cycle, then run forever until reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = AW'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_o   <= (state_d == S_RUN);
    end
  end

  // Shared write port: the sweep owns it during clear, user writes only in run.
  assign mem_we    = rst_n & (clr_we | ((state_q == S_RUN) & we_i));
  assign mem_waddr = clr_we ? clr_cnt_q : waddr_i;
  assign mem_wdata = clr_we ? INIT_VAL : wdata_i;

  for (genvar k = 0; k < NR; k++) begin : g_port
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] mem_rd;
    logic [WIDTH-1:0] rd_c;

    assign ra = raddr_i[k*AW +: AW];

    lutram_1r1w #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (ra),
      .rdata (mem_rd)
    );

    // Storage is undefined until swept, so clear-phase reads are forced.
    always_comb begin
      rd_c = mem_rd;
      if (state_q == S_CLEAR) begin
        rd_c = INIT_VAL;
      end else if (BYPASS && we_i && (ra == waddr_i)) begin
        rd_c = wdata_i;
      end
    end

    if (OUT_REG) begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_c;
        end
      end
      assign rdata_o[k*WIDTH +: WIDTH] = rd_q;
    end else begin : g_comb
      assign rdata_o[k*WIDTH +: WIDTH] = rd_c;
    end
  end

endmodule

// File: tb/tb_mpram_nr1w.sv
// Randomized and directed bench for mpram_nr1w; two configurations run side by side.
module tb_mpram_nr1w;

  localparam int unsigned D0 = 32, W0 = 2, N0 = 3, A0 = 5;
  localparam int unsigned D1 = 64, W1 = 7, N1 = 5, A1 = 6;
  localparam logic [W0-1:0] I0 = 2'b01;
  localparam logic [W1-1:0] I1 = 7'h55;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             we0, rdy0;
  logic [A0-1:0]    wa0;
  logic [W0-1:0]    wd0;
  logic [N0*A0-1:0] ra0;
  logic [N0*W0-1:0] rd0;

  logic             we1, rdy1;
  logic [A1-1:0]    wa1;
  logic [W1-1:0]    wd1;
  logic [N1*A1-1:0] ra1;
  logic [N1*W1-1:0] rd1;

  // Combinational read, bypass on
  mpram_nr1w #(
    .DEPTH(D0), .WIDTH(W0), .NR(N0), .BYPASS(1'b1), .OUT_REG(1'b0), .INIT_VAL(I0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .ready_o(rdy0), .we_i(we0), .waddr_i(wa0),
    .wdata_i(wd0), .raddr_i(ra0), .rdata_o(rd0)
  );

  // Registered read, read-before-write
  mpram_nr1w #(
    .DEPTH(D1), .WIDTH(W1), .NR(N1), .BYPASS(1'b0), .OUT_REG(1'b1), .INIT_VAL(I1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ready_o(rdy1), .we_i(we1), .waddr_i(wa1),
    .wdata_i(wd1), .raddr_i(ra1), .rdata_o(rd1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: contents as seen by a reader, plus edges since reset release.
  logic [W0-1:0] m0 [D0];
  logic [W1-1:0] m1 [D1];
  int            cnt0, cnt1;
  logic [W1-1:0] exp1 [N1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    cnt0 = 0;
    cnt1 = 0;
    foreach (m0[i]) m0[i] = I0;
    foreach (m1[i]) m1[i] = I1;
  endtask

  task automatic drive(input logic we, input int wa, input int wd, input int ra);
    we0 = we;
    we1 = we;
    wa0 = A0'(wa);
    wa1 = A1'(wa);
    wd0 = W0'(wd);
    wd1 = W1'(wd);
    for (int k = 0; k < N0; k++) ra0[k*A0 +: A0] = A0'(ra);
    for (int k = 0; k < N1; k++) ra1[k*A1 +: A1] = A1'(ra);
  endtask

  // One clock: check comb outputs before the edge, advance model, check registered outputs.
  task automatic tick();
    logic [A0-1:0] a;
    logic [A1-1:0] b;
    logic [W0-1:0] e0;
    #1;
    check("ready0", 32'(rdy0), 32'(cnt0 >= int'(D0)));
    check("ready1", 32'(rdy1), 32'(cnt1 >= int'(D1)));
    for (int k = 0; k < N0; k++) begin
      a = ra0[k*A0 +: A0];
      if (cnt0 < int'(D0))            e0 = I0;
      else if (we0 && (a == wa0))     e0 = wd0;
      else                            e0 = m0[a];
      check($sformatf("rd0[%0d]", k), 32'(rd0[k*W0 +: W0]), 32'(e0));
    end
    for (int k = 0; k < N1; k++) begin
      b = ra1[k*A1 +: A1];
      if (!rst_n)                     exp1[k] = '0;
      else if (cnt1 < int'(D1))       exp1[k] = I1;
      else                            exp1[k] = m1[b];
    end
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      if (cnt0 >= int'(D0) && we0) m0[wa0] = wd0;
      if (cnt1 >= int'(D1) && we1) m1[wa1] = wd1;
      if (cnt0 < int'(D0)) cnt0++;
      if (cnt1 < int'(D1)) cnt1++;
    end
    #1;
    for (int k = 0; k < N1; k++) begin
      check($sformatf("rd1[%0d]", k), 32'(rd1[k*W1 +: W1]), 32'(exp1[k]));
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    reset_model();
    @(negedge clk);
    tick();

    // Sweep, then read back every address
    rst_n = 1'b1;
    repeat (D1) tick();
    for (int a = 0; a < int'(D1); a++) begin
      drive(1'b0, 0, 0, a);
      tick();
    end

    // Write then read on all ports
    drive(1'b1, 5, 3, 0);
    tick();
    drive(1'b0, 0, 0, 5);
    tick();
    tick();

    // Same-cycle collision: bypass on dut0, old data on dut1
    drive(1'b1, 7, 1, 0);
    tick();
    drive(1'b1, 7, 2, 7);
    tick();
    drive(1'b0, 0, 0, 7);
    tick();
    tick();

    // Write during the sweep is ignored
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    drive(1'b1, 3, 3, 3);
    tick();
    drive(1'b0, 0, 0, 3);
    repeat (D1) tick();
    tick();

    // Reset mid-sweep, then reset in run after a write
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (D1) tick();
    drive(1'b1, 9, 3, 0);
    tick();
    drive(1'b0, 0, 0, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (D1) tick();
    tick();
    tick();

    // Random traffic with occasional resets and biased address collisions
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(0, 1999) != 0);
      we0 = 1'($urandom_range(0, 1));
      wa0 = A0'($urandom);
      wd0 = W0'($urandom);
      for (int k = 0; k < N0; k++)
        ra0[k*A0 +: A0] = ($urandom_range(0, 3) == 0) ? wa0 : A0'($urandom);
      we1 = 1'($urandom_range(0, 1));
      wa1 = A1'($urandom);
      wd1 = W1'($urandom);
      for (int k = 0; k < N1; k++)
        ra1[k*A1 +: A1] = ($urandom_range(0, 3) == 0) ? wa1 : A1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
